pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//   Scoreboard-based RAW hazard and forwarding controller for the next-generation pipelined CPU.
//   Tracks the destination register of every in-flight instruction in the EX..WB stages.
//   Each cycle it tells decode either to stall, or which stage result register each source operand takes.
//   Sits beside the decode stage; its select outputs are registered into EX with the operands.
// PARAMETERS
//   REG_BITS  5  register index width
//   STAGES    3  tracked stages after ID: 1=EX, 2=MEM, 3=WB; legal range 2..7
//   MUL_LAT   2  multiplier latency in cycles; constraint 1+MUL_LAT <= STAGES
//   FWD_EN    1  1 = forwarding enabled; 0 = interlock only, all sels forced 0
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   id_valid     in   1         valid instruction in ID
//   id_a_reg     in   REG_BITS  source A index
//   id_a_used    in   1         source A read by instruction
//   id_b_reg     in   REG_BITS  source B index
//   id_b_used    in   1         source B read by instruction
//   id_wb_en     in   1         instruction writes a register
//   id_wb_reg    in   REG_BITS  destination index
//   id_is_load   in   1         result comes from data memory
//   id_is_mul    in   1         result comes from multiplier
//   flush        in   1         kill the instruction currently in ID
//   stall        out  1         hold PC and IF/ID; insert bubble into EX
//   fwd_a_sel    out  SW        SW=$clog2(STAGES+1); 0 = register file, k = result register of stage k
//   fwd_b_sel    out  SW        same encoding for operand B
//   inflight     out  3         count of valid scoreboard entries, registered
//   stall_cnt    out  32        stall cycles since reset, saturating at 32'hFFFFFFFF
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//   - All entries invalid; inflight=0, stall_cnt=0.
//   - stall=0, fwd_a_sel=0, fwd_b_sel=0 immediately, with no clock edge.
//   Entries s[1..STAGES] hold {valid, wb_en, reg, rdy}.
//   - rdy=2 for ALU ops; 3 for loads; 1+MUL_LAT for mul. id_is_load takes priority over id_is_mul.
//   Every clock: s[k+1]<=s[k]; s[STAGES] retires (register file written that edge).
//   - s[1] <= new entry when id_valid & !stall & !flush; otherwise s[1] gets a bubble (valid=0).
//   Operand lookup, combinational, done per operand X in {a,b}:
//   - Active only if id_valid & id_X_used & id_X_reg != 0.
//   - Find the youngest k (smallest index) with s[k].valid & s[k].wb_en & s[k].reg == id_X_reg.
//   - No match: sel=0, no hazard.
//   - k == STAGES: sel=0, no hazard (register file is written before the consumer reads).
//   - k < STAGES, FWD_EN=1: if k+1 >= s[k].rdy then sel=k+1 (the producer's stage next cycle); else hazard, sel=0.
//   - k < STAGES, FWD_EN=0: hazard, sel=0.
//   stall = (hazard on A | hazard on B) & !flush.
//   - flush wins over a simultaneous hazard: stall=0 and a bubble enters.
//   - While stall=1 both sels are 0.
//   A stalled instruction re-evaluates every cycle, because entries advance while ID is held.
//   Register index 0 is never a hazard, even if an in-flight entry targets r0.
//   id_valid=0 gives stall=0 and sels=0.
//   inflight updates each edge to the popcount of valid entries after the shift.
//   stall_cnt increments on every edge where stall=1.
// TESTING
//   1. ALU r3<=r1+r2, then ALU using r3 next cycle -> stall=0, fwd_a_sel=2; one cycle later a user gets fwd=3.
//   2. Load r5, then ADD r6<=r5+r1 back-to-back -> stall=1 for exactly 1 cycle, then fwd_a_sel=3, stall_cnt=1.
//   3. MUL r7 (MUL_LAT=2), then consumer of r7 on both operands -> 1 stall cycle, then fwd_a_sel=fwd_b_sel=3.
//   4. FWD_EN=0: ALU r3, then consumer of r3 -> stall=1 for 2 cycles, sel=0, issues as producer reaches s[3].
//   5. Load r5 followed by consumer with flush=1 in the same cycle -> stall=0; bubble in s[1]; inflight stays 1.
//   6. Assert rst=0 mid-stall with 3 entries in flight -> stall, sels and inflight go to 0 without a clock edge.
//      After release, the first instruction issues with no hazard.

Source files
------------

// File: rtl/pipe_hazard_unit_if.sv
// Decode-side hazard/forwarding bundle: decode drives the ID instruction (master),
// the hazard unit returns stall, operand selects and status (slave).
interface pipe_hazard_unit_if #(
  parameter int REG_BITS = 5,
  parameter int STAGES   = 3
);
  localparam int SW = $clog2(STAGES + 1);

  logic                id_valid;
  logic [REG_BITS-1:0] id_a_reg;
  logic                id_a_used;
  logic [REG_BITS-1:0] id_b_reg;
  logic                id_b_used;
  logic                id_wb_en;
  logic [REG_BITS-1:0] id_wb_reg;
  logic                id_is_load;
  logic                id_is_mul;
  logic                flush;
  logic                stall;
  logic [SW-1:0]       fwd_a_sel;
  logic [SW-1:0]       fwd_b_sel;
  logic [2:0]          inflight;
  logic [31:0]         stall_cnt;

  modport master (
    output id_valid, id_a_reg, id_a_used, id_b_reg, id_b_used,
           id_wb_en, id_wb_reg, id_is_load, id_is_mul, flush,
    input  stall, fwd_a_sel, fwd_b_sel, inflight, stall_cnt
  );

  modport slave (
    input  id_valid, id_a_reg, id_a_used, id_b_reg, id_b_used,
           id_wb_en, id_wb_reg, id_is_load, id_is_mul, flush,
    output stall, fwd_a_sel, fwd_b_sel, inflight, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard RAW hazard detector and forwarding-select generator for the decode stage.
// Entry k describes the instruction in stage k (1=EX .. STAGES=WB).
module pipe_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int STAGES   = 3,
  parameter int MUL_LAT  = 2,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_unit_if.slave  hz
);
  localparam int SW = $clog2(STAGES + 1);
  localparam int RW = 3;
  localparam logic [RW-1:0] RDY_ALU  = RW'(2);
  localparam logic [RW-1:0] RDY_LOAD = RW'(3);
  localparam logic [RW-1:0] RDY_MUL  = RW'(1 + MUL_LAT);

  logic [STAGES:1]               valid_q, valid_d;
  logic [STAGES:1]               wb_en_q, wb_en_d;
  logic [STAGES:1][REG_BITS-1:0] reg_q, reg_d;
  logic [STAGES:1][RW-1:0]       rdy_q, rdy_d;
  logic [2:0]                    inflight_q, inflight_d;
  logic [31:0]                   stall_cnt_q, stall_cnt_d;

  logic [1:0][REG_BITS-1:0] src_reg;
  logic [1:0]               src_used;
  logic [1:0]               hazard;
  logic [1:0][SW-1:0]       sel_raw;
  logic                     stall;
  logic                     issue;

  assign src_reg  = {hz.id_b_reg, hz.id_a_reg};
  assign src_used = {hz.id_b_used, hz.id_a_used};

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic          haz;
    logic          found;
    logic [SW-1:0] sel;

    // Ascending scan with a found flag picks the youngest matching producer.
    always_comb begin
      haz   = 1'b0;
      sel   = '0;
      found = 1'b0;
      if (hz.id_valid && src_used[gi] && (src_reg[gi] != '0)) begin
        for (int k = 1; k <= STAGES; k++) begin
          if (!found && valid_q[k] && wb_en_q[k] && (reg_q[k] == src_reg[gi])) begin
            found = 1'b1;
            if (k < STAGES) begin
              if (FWD_EN && ((k + 1) >= int'(rdy_q[k]))) begin
                sel = SW'(k + 1);
              end else begin
                haz = 1'b1;
              end
            end
          end
        end
      end
    end

    assign hazard[gi]  = haz;
    assign sel_raw[gi] = sel;
  end

  assign stall = (|hazard) && !hz.flush;
  assign issue = hz.id_valid && !stall && !hz.flush;

  assign hz.stall     = stall;
  assign hz.fwd_a_sel = stall ? '0 : sel_raw[0];
  assign hz.fwd_b_sel = stall ? '0 : sel_raw[1];
  assign hz.inflight  = inflight_q;
  assign hz.stall_cnt = stall_cnt_q;

  always_comb begin
    valid_d[1] = issue;
    wb_en_d[1] = hz.id_wb_en;
    reg_d[1]   = hz.id_wb_reg;
    if (hz.id_is_load) begin
      rdy_d[1] = RDY_LOAD;
    end else if (hz.id_is_mul) begin
      rdy_d[1] = RDY_MUL;
    end else begin
      rdy_d[1] = RDY_ALU;
    end
  end

  for (genvar gi = 2; gi <= STAGES; gi++) begin : g_shift
    assign valid_d[gi] = valid_q[gi-1];
    assign wb_en_d[gi] = wb_en_q[gi-1];
    assign reg_d[gi]   = reg_q[gi-1];
    assign rdy_d[gi]   = rdy_q[gi-1];
  end

  always_comb begin
    inflight_d = '0;
    for (int k = 1; k <= STAGES; k++) begin
      inflight_d = inflight_d + 3'(valid_d[k]);
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wb_en_q     <= '0;
      reg_q       <= '0;
      rdy_q       <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wb_en_q     <= wb_en_d;
      reg_q       <= reg_d;
      rdy_q       <= rdy_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Drives identical ID traffic into a forwarding and an interlock-only hazard unit and
// compares both against an issue-timeline model of the pipeline.
module tb_pipe_hazard_unit;
  localparam int STAGES  = 3;
  localparam int MUL_LAT = 2;
  localparam int NC      = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, a_used, b_used, wb_en, is_load, is_mul, flush;
  logic [4:0] a_reg, b_reg, wb_reg;

  pipe_hazard_unit_if #(.REG_BITS(5), .STAGES(STAGES)) if0 ();
  pipe_hazard_unit_if #(.REG_BITS(5), .STAGES(STAGES)) if1 ();

  assign if0.id_valid = id_valid;    assign if1.id_valid = id_valid;
  assign if0.id_a_reg = a_reg;       assign if1.id_a_reg = a_reg;
  assign if0.id_a_used = a_used;     assign if1.id_a_used = a_used;
  assign if0.id_b_reg = b_reg;       assign if1.id_b_reg = b_reg;
  assign if0.id_b_used = b_used;     assign if1.id_b_used = b_used;
  assign if0.id_wb_en = wb_en;       assign if1.id_wb_en = wb_en;
  assign if0.id_wb_reg = wb_reg;     assign if1.id_wb_reg = wb_reg;
  assign if0.id_is_load = is_load;   assign if1.id_is_load = is_load;
  assign if0.id_is_mul = is_mul;     assign if1.id_is_mul = is_mul;
  assign if0.flush = flush;          assign if1.flush = flush;

  pipe_hazard_unit #(.REG_BITS(5), .STAGES(STAGES), .MUL_LAT(MUL_LAT), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .hz(if0)
  );
  pipe_hazard_unit #(.REG_BITS(5), .STAGES(STAGES), .MUL_LAT(MUL_LAT), .FWD_EN(1'b0)) u_ilk (
    .clk(clk), .rst_n(rst_n), .hz(if1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Timeline model: what each unit issued in every cycle since its last reset.
  bit         hv   [2][NC];
  bit         hwb  [2][NC];
  logic [4:0] hreg [2][NC];
  int         hrdy [2][NC];
  int         base [2];
  int         scnt [2];
  int         cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void lookup(input int m, input bit used, input logic [4:0] r,
                                 output bit haz, output int sel);
    bit done;
    done = 1'b0;
    haz  = 1'b0;
    sel  = 0;
    if (id_valid && used && r != 5'd0) begin
      for (int k = 1; k <= STAGES; k++) begin
        int c;
        c = cyc - k;
        if (!done && c >= base[m] && hv[m][c] && hwb[m][c] && hreg[m][c] == r) begin
          done = 1'b1;
          // A producer in the last stage writes the register file before the consumer reads.
          if (k < STAGES) begin
            if (m == 0 && k + 1 >= hrdy[m][c]) sel = k + 1;
            else haz = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic int occupancy(input int m);
    int n;
    n = 0;
    for (int k = 1; k <= STAGES; k++)
      if (cyc - k >= base[m] && hv[m][cyc-k]) n++;
    return n;
  endfunction

  task automatic put(input bit v, input logic [4:0] ra, input bit ua, input logic [4:0] rb,
                     input bit ub, input bit we, input logic [4:0] rw, input bit ld,
                     input bit mu, input bit fl);
    id_valid = v;  a_reg = ra; a_used = ua; b_reg = rb; b_used = ub;
    wb_en = we; wb_reg = rw; is_load = ld; is_mul = mu; flush = fl;
  endtask

  task automatic cycle();
    bit st [2];
    int sa [2];
    int sb [2];
    int occ [2];
    bit ha, hb;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      lookup(m, a_used, a_reg, ha, sa[m]);
      lookup(m, b_used, b_reg, hb, sb[m]);
      st[m] = (ha || hb) && !flush;
      if (st[m]) begin sa[m] = 0; sb[m] = 0; end
      occ[m] = occupancy(m);
    end
    chk("fwd.stall", 64'(if0.stall), 64'(st[0]));
    chk("fwd.sel_a", 64'(if0.fwd_a_sel), 64'(sa[0]));
    chk("fwd.sel_b", 64'(if0.fwd_b_sel), 64'(sb[0]));
    chk("fwd.inflight", 64'(if0.inflight), 64'(occ[0]));
    chk("fwd.stall_cnt", 64'(if0.stall_cnt), 64'(scnt[0]));
    chk("ilk.stall", 64'(if1.stall), 64'(st[1]));
    chk("ilk.sel_a", 64'(if1.fwd_a_sel), 64'(sa[1]));
    chk("ilk.sel_b", 64'(if1.fwd_b_sel), 64'(sb[1]));
    chk("ilk.inflight", 64'(if1.inflight), 64'(occ[1]));
    chk("ilk.stall_cnt", 64'(if1.stall_cnt), 64'(scnt[1]));
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      hv[m][cyc]   = id_valid && !st[m] && !flush;
      hwb[m][cyc]  = wb_en;
      hreg[m][cyc] = wb_reg;
      hrdy[m][cyc] = is_load ? 3 : (is_mul ? 1 + MUL_LAT : 2);
      if (st[m]) scnt[m]++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.fwd.stall", 64'(if0.stall), 64'd0);
    chk("rst.fwd.sel_a", 64'(if0.fwd_a_sel), 64'd0);
    chk("rst.fwd.sel_b", 64'(if0.fwd_b_sel), 64'd0);
    chk("rst.fwd.inflight", 64'(if0.inflight), 64'd0);
    chk("rst.fwd.stall_cnt", 64'(if0.stall_cnt), 64'd0);
    chk("rst.ilk.stall", 64'(if1.stall), 64'd0);
    chk("rst.ilk.inflight", 64'(if1.inflight), 64'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      base[m] = cyc;
      scnt[m] = 0;
    end
  endtask

  initial begin
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    do_reset();

    // ALU producer, then two back-to-back consumers of r3.
    put(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0); cycle();
    put(1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0, 0); cycle();
    put(1, 5'd3, 1, 5'd0, 0, 1, 5'd8, 0, 0, 0); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // Load-use: consumer presented until both units let it through.
    put(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 1, 0, 0); cycle();
    put(1, 5'd5, 1, 5'd1, 1, 1, 5'd6, 0, 0, 0); repeat (3) cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // Multiplier result consumed on both operands.
    put(1, 5'd1, 1, 5'd2, 1, 1, 5'd7, 0, 1, 0); cycle();
    put(1, 5'd7, 1, 5'd7, 1, 1, 5'd9, 0, 0, 0); repeat (3) cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // Load followed by a flushed consumer; then r0 producer must never cause a hazard.
    put(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 1, 0, 0); cycle();
    put(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0, 1); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    put(1, 5'd1, 1, 5'd2, 1, 1, 5'd0, 1, 0, 0); cycle();
    put(1, 5'd0, 1, 5'd0, 1, 1, 5'd4, 0, 0, 0); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // Reset asserted while a load-use stall holds ID with three entries in flight.
    put(1, 5'd0, 0, 5'd0, 0, 1, 5'd1, 0, 0, 0); cycle();
    put(1, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 0, 0); cycle();
    put(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 1, 0, 0); cycle();
    put(1, 5'd5, 1, 5'd2, 1, 1, 5'd6, 0, 0, 0);
    #2;
    chk("prerst.fwd.stall", 64'(if0.stall), 64'd1);
    chk("prerst.fwd.inflight", 64'(if0.inflight), 64'd3);
    do_reset();
    cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    for (int i = 0; i < 1500; i++) begin
      put($urandom_range(0, 7) != 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
